// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory: store size, address width and the
// loader's frame-parsing states. Read and write sides import these so they agree on size.
package imem_loader_pkg;

    localparam int unsigned IMEM_SIZE   = 1024;
    localparam int unsigned IMEM_ADDR_W = 10;

    typedef enum logic [1:0] {
        S_ADDR_LO = 2'd0,
        S_ADDR_HI = 2'd1,
        S_DATA    = 2'd2,
        S_DRAIN   = 2'd3
    } load_state_t;

    // The full 16-bit frame address is compared, so 0x0400 and above never alias into the store.
    function automatic logic addr_in_range(input logic [15:0] addr, input int unsigned size);
        return (32'(addr) < size);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory write-side loader: parses framed byte streams (2-byte base address
// followed by payload) into registered single-byte writes and stalls fetch meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_SIZE = IMEM_SIZE,
    parameter int unsigned ADDR_W   = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    // Stream handshake: a byte transfers on a rising edge where in_valid && in_ready are both
    // high; in_data/in_last are only meaningful then. The loader never back-pressures, so
    // in_ready is high in every cycle except while rst_n is held low.
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              fetch_hold,
    output logic              done,
    output logic              load_error,
    output logic [ADDR_W:0]   byte_count,
    output logic [1:0]        state_dbg
);

    load_state_t       state, state_d;
    logic [15:0]       cur_addr, cur_addr_d;
    logic [7:0]        addr_lo, addr_lo_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [7:0]        wr_data_d;
    logic              done_d;
    logic              load_error_d;
    logic [ADDR_W:0]   byte_count_d;
    logic              accept;
    logic [15:0]       hdr_addr;

    assign in_ready   = rst_n;
    assign accept     = in_valid && in_ready;
    assign hdr_addr   = {in_data, addr_lo};
    assign fetch_hold = (state != S_ADDR_LO) || wr_en;
    assign state_dbg  = state;

    always_comb begin
        state_d      = state;
        cur_addr_d   = cur_addr;
        addr_lo_d    = addr_lo;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        done_d       = 1'b0;
        load_error_d = load_error;
        byte_count_d = byte_count;

        if (accept) begin
            unique case (state)
                S_ADDR_LO: begin
                    addr_lo_d    = in_data;
                    byte_count_d = '0;
                    // A frame that ends on its first byte is a truncated header.
                    if (in_last) begin
                        load_error_d = 1'b1;
                    end else begin
                        load_error_d = 1'b0;
                        state_d      = S_ADDR_HI;
                    end
                end

                S_ADDR_HI: begin
                    cur_addr_d = hdr_addr;
                    if (in_last) begin
                        load_error_d = 1'b1;
                        state_d      = S_ADDR_LO;
                    end else if (!addr_in_range(hdr_addr, MEM_SIZE)) begin
                        load_error_d = 1'b1;
                        state_d      = S_DRAIN;
                    end else begin
                        state_d = S_DATA;
                    end
                end

                S_DATA: begin
                    if (addr_in_range(cur_addr, MEM_SIZE)) begin
                        wr_en_d      = 1'b1;
                        wr_addr_d    = cur_addr[ADDR_W-1:0];
                        wr_data_d    = in_data;
                        cur_addr_d   = cur_addr + 16'd1;
                        byte_count_d = byte_count + (ADDR_W+1)'(1);
                        if (in_last) begin
                            done_d  = 1'b1;
                            state_d = S_ADDR_LO;
                        end
                    end else begin
                        // Ran off the end of the store: no wrap, discard the rest of the frame.
                        load_error_d = 1'b1;
                        state_d      = in_last ? S_ADDR_LO : S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (in_last) begin
                        state_d = S_ADDR_LO;
                    end
                end

                default: state_d = S_ADDR_LO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_ADDR_LO;
            cur_addr   <= '0;
            addr_lo    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            load_error <= 1'b0;
            byte_count <= '0;
        end else begin
            state      <= state_d;
            cur_addr   <= cur_addr_d;
            addr_lo    <= addr_lo_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            done       <= done_d;
            load_error <= load_error_d;
            byte_count <= byte_count_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives framed byte streams and checks the registered
// write port, done/load_error/byte_count and fetch_hold against hand-computed values.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        fetch_hold;
    logic        done;
    logic        load_error;
    logic [10:0] byte_count;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fetch_hold (fetch_hold),
        .done       (done),
        .load_error (load_error),
        .byte_count (byte_count),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Drive one cycle's inputs at the falling edge, let a rising edge pass, and return at the
    // next falling edge where the registered results of that cycle are visible.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input logic [9:0] a, input logic [7:0] d,
                             input logic dn);
        chk({tag, "_wr_en"}, wr_en, 1'b1);
        chk({tag, "_wr_addr"}, wr_addr, a);
        chk({tag, "_wr_data"}, wr_data, d);
        chk({tag, "_done"}, done, dn);
    endtask

    logic [7:0] t1_data [4];

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        t1_data  = '{8'h30, 8'hF2, 8'h0A, 8'h00};
        @(negedge clk);

        // reset state
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 10'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_load_error", load_error, 1'b0);
        chk("rst_byte_count", byte_count, 11'd0);
        chk("rst_fetch_hold", fetch_hold, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_state", state_dbg, S_ADDR_LO);

        // 1: frame 00 00 30 F2 0A 00(last) -> addr 0..3
        cycle(1'b1, 8'h00, 1'b0);
        chk("t1_hdr0_wr_en", wr_en, 1'b0);
        chk("t1_hdr0_hold", fetch_hold, 1'b1);
        cycle(1'b1, 8'h00, 1'b0);
        chk("t1_hdr1_wr_en", wr_en, 1'b0);
        chk("t1_hdr1_state", state_dbg, S_DATA);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, t1_data[i], (i == 3));
            chk_write($sformatf("t1_b%0d", i), 10'(i), t1_data[i], (i == 3));
        end
        chk("t1_byte_count", byte_count, 11'd4);
        chk("t1_load_error", load_error, 1'b0);
        chk("t1_hold_last", fetch_hold, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t1_after_wr_en", wr_en, 1'b0);
        chk("t1_after_done", done, 1'b0);
        chk("t1_after_hold", fetch_hold, 1'b0);

        // 2: base 0x3FE, overrun on third payload byte, drain to in_last
        cycle(1'b1, 8'hFE, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        cycle(1'b1, 8'h11, 1'b0);
        chk_write("t2_b0", 10'h3FE, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        chk_write("t2_b1", 10'h3FF, 8'h22, 1'b0);
        chk("t2_b1_err", load_error, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        chk("t2_b2_wr_en", wr_en, 1'b0);
        chk("t2_b2_err", load_error, 1'b1);
        chk("t2_b2_state", state_dbg, S_DRAIN);
        cycle(1'b1, 8'h44, 1'b1);
        chk("t2_drain_wr_en", wr_en, 1'b0);
        chk("t2_drain_done", done, 1'b0);
        chk("t2_drain_hold", fetch_hold, 1'b0);
        chk("t2_byte_count", byte_count, 11'd2);
        chk("t2_err_sticky", load_error, 1'b1);

        // 3: base 0x400 is out of range; 5 bytes discarded
        cycle(1'b1, 8'h00, 1'b0);
        chk("t3_err_cleared", load_error, 1'b0);
        chk("t3_count_cleared", byte_count, 11'd0);
        cycle(1'b1, 8'h04, 1'b0);
        chk("t3_hdr_err", load_error, 1'b1);
        chk("t3_hdr_state", state_dbg, S_DRAIN);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_ready%0d", i), in_ready, 1'b1);
            cycle(1'b1, 8'(8'h50 + i), (i == 4));
            chk($sformatf("t3_wr_en%0d", i), wr_en, 1'b0);
        end
        chk("t3_done", done, 1'b0);
        chk("t3_hold", fetch_hold, 1'b0);
        chk("t3_byte_count", byte_count, 11'd0);

        // 4: bubbles between payload bytes; bubble carries a stray in_last that must be ignored
        cycle(1'b1, 8'h20, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(8'hA0 + i), (i == 3));
            chk_write($sformatf("t4_b%0d", i), 10'(10'h020 + i), 8'(8'hA0 + i), (i == 3));
            if (i < 3) begin
                cycle(1'b0, 8'hFF, 1'b1);
                chk($sformatf("t4_bubble%0d_wr_en", i), wr_en, 1'b0);
                chk($sformatf("t4_bubble%0d_hold", i), fetch_hold, 1'b1);
                chk($sformatf("t4_bubble%0d_cnt", i), byte_count, 11'(i + 1));
            end
        end
        chk("t4_byte_count", byte_count, 11'd4);

        // 5: reset mid-frame, then a one-byte frame at 0x010
        cycle(1'b1, 8'h40, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b1, 8'h66, 1'b0);
        chk_write("t5_pre", 10'h041, 8'h66, 1'b0);
        rst_n = 1'b0;
        cycle(1'b1, 8'h77, 1'b0);
        chk("t5_rst_wr_en", wr_en, 1'b0);
        chk("t5_rst_wr_addr", wr_addr, 10'd0);
        chk("t5_rst_wr_data", wr_data, 8'd0);
        chk("t5_rst_done", done, 1'b0);
        chk("t5_rst_err", load_error, 1'b0);
        chk("t5_rst_count", byte_count, 11'd0);
        chk("t5_rst_hold", fetch_hold, 1'b0);
        chk("t5_rst_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        cycle(1'b1, 8'h10, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1);
        chk_write("t5_new", 10'h010, 8'hAA, 1'b1);
        chk("t5_new_count", byte_count, 11'd1);

        // 6: truncated and header-only frames, then back-to-back good frames
        cycle(1'b1, 8'h05, 1'b1);
        chk("t6_trunc_err", load_error, 1'b1);
        chk("t6_trunc_hold", fetch_hold, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        chk("t6_hdronly_clr", load_error, 1'b0);
        cycle(1'b1, 8'h02, 1'b1);
        chk("t6_hdronly_err", load_error, 1'b1);
        chk("t6_hdronly_state", state_dbg, S_ADDR_LO);
        chk("t6_hdronly_done", done, 1'b0);
        cycle(1'b1, 8'h08, 1'b0);
        chk("t6_f1_err_clr", load_error, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'hB1, 1'b0);
        chk_write("t6_f1_b0", 10'h008, 8'hB1, 1'b0);
        cycle(1'b1, 8'hB2, 1'b1);
        chk_write("t6_f1_b1", 10'h009, 8'hB2, 1'b1);
        cycle(1'b1, 8'h0C, 1'b0);
        chk("t6_f2_hdr0_wr_en", wr_en, 1'b0);
        chk("t6_f2_hdr0_done", done, 1'b0);
        chk("t6_f2_hdr0_state", state_dbg, S_ADDR_HI);
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'hC1, 1'b1);
        chk_write("t6_f2_b0", 10'h00C, 8'hC1, 1'b1);
        chk("t6_f2_count", byte_count, 11'd1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t6_end_hold", fetch_hold, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
